// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT stage sequencer: FSM state
// encoding, FFT size helpers and the bit-reverse function.
package fft_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_DRAIN_LAST = 3'd3,
    ST_DONE       = 3'd4
  } fft_seq_state_e;

  // FFT length N = 2**n_log2
  function automatic int unsigned fft_n(input int unsigned n_log2);
    return 32'd1 << n_log2;
  endfunction

  // N/2: butterflies per stage and twiddle ROM depth
  function automatic int unsigned fft_half(input int unsigned n_log2);
    return fft_n(n_log2) >> 1;
  endfunction

  // N/4: offset between the two twiddle lookups
  function automatic int unsigned fft_quarter(input int unsigned n_log2);
    return fft_n(n_log2) >> 2;
  endfunction

  // Bits needed to hold a stage index 0..n_log2-1
  function automatic int unsigned fft_stage_w(input int unsigned n_log2);
    return (n_log2 <= 2) ? 1 : $clog2(n_log2);
  endfunction

  // Reverse the low w bits of x; bits above w come back as zero
  function automatic logic [31:0] fft_bit_rev(input logic [31:0] x, input int unsigned w);
    logic [31:0] v;
    logic [31:0] r;
    v = x;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to align
// issue-time controls with the butterfly input and write-back stages.
module fft_seq_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Zero latency: straight wire
      assign o_q = i_d;
    end else if (DEPTH == 1) begin : g_one
      logic [WIDTH-1:0] r_pipe;

      // Single register stage
      always_ff @(posedge i_clk) begin
        if (i_clr) r_pipe <= '0;
        else       r_pipe <= i_d;
      end

      assign o_q = r_pipe;
    end else begin : g_many
      logic [DEPTH*WIDTH-1:0] r_pipe;

      // Shift new sample in at the bottom, oldest leaves at the top
      always_ff @(posedge i_clk) begin
        if (i_clr) r_pipe <= '0;
        else       r_pipe <= {r_pipe[(DEPTH-1)*WIDTH-1:0], i_d};
      end

      assign o_q = r_pipe[DEPTH*WIDTH-1 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/fft_r2_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Issues one butterfly read per cycle, drains the pipeline between stages
// so the first read of a stage follows the last write of the previous one,
// and aligns butterfly enables and write-back addresses to the datapath.
// Optional: define FFT_SEQ_BITREV_EN to bit-reverse stage-0 read addresses
// (input frame stored in natural order); write addresses stay natural.
module fft_r2_stage_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N_LOG2   = 4,
  parameter  int unsigned TW_W     = N_LOG2 - 1,
  parameter  int unsigned RD_LAT   = 1,
  parameter  int unsigned PIPE_LAT = 3,
  localparam int unsigned ST_W     = fft_stage_w(N_LOG2)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cfg_modify,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [ST_W-1:0]   o_stage,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  output logic [TW_W-1:0]   o_tw_addr,
  output logic [TW_W-1:0]   o_tw2_addr,
  output logic              o_bf_en,
  output logic              o_bf_en_modify,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b
);

  localparam int unsigned K_W   = N_LOG2 - 1;
  localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1);
  localparam int unsigned WB_W  = 1 + 2 * N_LOG2;

  localparam logic [K_W-1:0]   K_LAST   = K_W'(fft_half(N_LOG2) - 1);
  localparam logic [ST_W-1:0]  S_LAST   = ST_W'(N_LOG2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [TW_W-1:0]  TW_QTR   = TW_W'(fft_quarter(N_LOG2));

  fft_seq_state_e    r_state;
  logic [K_W-1:0]    r_k;
  logic [ST_W-1:0]   r_s;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cfg_mod;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_rd_mod;
  logic [N_LOG2-1:0] r_rd_addr_a;
  logic [N_LOG2-1:0] r_rd_addr_b;
  logic [TW_W-1:0]   r_tw_addr;
  logic [TW_W-1:0]   r_tw2_addr;

  logic [N_LOG2-1:0] w_k_ext;
  logic [N_LOG2-1:0] w_span;
  logic [N_LOG2-1:0] w_low_mask;
  logic [N_LOG2-1:0] w_addr_a_nat;
  logic [N_LOG2-1:0] w_addr_b_nat;
  logic [N_LOG2-1:0] w_addr_a;
  logic [N_LOG2-1:0] w_addr_b;
  logic [ST_W-1:0]   w_tw_shift;
  logic [TW_W-1:0]   w_tw;
  logic [TW_W-1:0]   w_tw2;
  logic [N_LOG2-1:0] w_wb_src_a;
  logic [N_LOG2-1:0] w_wb_src_b;
  logic [1:0]        w_bf_q;
  logic [WB_W-1:0]   w_wb_q;

`ifdef FFT_SEQ_BITREV_EN
  logic [N_LOG2-1:0] r_nat_a;
  logic [N_LOG2-1:0] r_nat_b;
`endif

  // Butterfly operand and twiddle addresses for the current (s, k)
  always_comb begin
    w_k_ext      = N_LOG2'(r_k);
    w_span       = N_LOG2'(1) << r_s;
    w_low_mask   = w_span - N_LOG2'(1);
    w_addr_a_nat = (((w_k_ext >> r_s) << r_s) << 1) | (w_k_ext & w_low_mask);
    w_addr_b_nat = w_addr_a_nat + w_span;
    w_tw_shift   = S_LAST - r_s;
    w_tw         = TW_W'((w_k_ext & w_low_mask) << w_tw_shift);
    w_tw2        = w_tw + TW_QTR;
    w_addr_a     = w_addr_a_nat;
    w_addr_b     = w_addr_b_nat;
`ifdef FFT_SEQ_BITREV_EN
    if (r_s == '0) begin
      w_addr_a = N_LOG2'(fft_bit_rev(32'(w_addr_a_nat), N_LOG2));
      w_addr_b = N_LOG2'(fft_bit_rev(32'(w_addr_b_nat), N_LOG2));
    end
`endif
  end

  // Sequencer FSM with registered issue outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_cfg_mod   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_mod    <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
      r_tw2_addr  <= '0;
`ifdef FFT_SEQ_BITREV_EN
      r_nat_a     <= '0;
      r_nat_b     <= '0;
`endif
    end else begin
      r_busy      <= (r_state == ST_RUN) || (r_state == ST_DRAIN) ||
                     (r_state == ST_DRAIN_LAST);
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_mod    <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
      r_tw2_addr  <= '0;
`ifdef FFT_SEQ_BITREV_EN
      r_nat_a     <= '0;
      r_nat_b     <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_RUN;
            r_cfg_mod <= i_cfg_modify;
            r_k       <= '0;
            r_s       <= '0;
            r_cnt     <= '0;
          end
        end
        ST_RUN: begin
          if (!i_hold) begin
            r_rd_en     <= 1'b1;
            r_rd_mod    <= r_cfg_mod && (r_s == S_LAST);
            r_rd_addr_a <= w_addr_a;
            r_rd_addr_b <= w_addr_b;
            r_tw_addr   <= w_tw;
            r_tw2_addr  <= w_tw2;
`ifdef FFT_SEQ_BITREV_EN
            r_nat_a     <= w_addr_a_nat;
            r_nat_b     <= w_addr_b_nat;
`endif
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_cnt   <= '0;
              r_state <= (r_s == S_LAST) ? ST_DRAIN_LAST : ST_DRAIN;
            end else begin
              r_k <= r_k + K_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_s     <= r_s + ST_W'(1);
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN_LAST: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_s     <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_BITREV_EN
  assign w_wb_src_a = r_nat_a;
  assign w_wb_src_b = r_nat_b;
`else
  assign w_wb_src_a = r_rd_addr_a;
  assign w_wb_src_b = r_rd_addr_b;
`endif

  // Butterfly enable/modify aligned with data arriving from RAM/ROM
  fft_seq_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_bf_dly (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_d   ({r_rd_en, r_rd_mod}),
    .o_q   (w_bf_q)
  );

  // Write strobe and natural-order addresses aligned with butterfly results
  fft_seq_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (WB_W)
  ) u_wb_dly (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_d   ({r_rd_en, w_wb_src_a, w_wb_src_b}),
    .o_q   (w_wb_q)
  );

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_stage        = r_s;
  assign o_rd_en        = r_rd_en;
  assign o_rd_addr_a    = r_rd_addr_a;
  assign o_rd_addr_b    = r_rd_addr_b;
  assign o_tw_addr      = r_tw_addr;
  assign o_tw2_addr     = r_tw2_addr;
  assign o_bf_en        = w_bf_q[1];
  assign o_bf_en_modify = w_bf_q[0];
  assign o_wr_en        = w_wb_q[WB_W-1];
  assign o_wr_addr_a    = w_wb_q[2*N_LOG2-1 -: N_LOG2];
  assign o_wr_addr_b    = w_wb_q[N_LOG2-1:0];

endmodule

// File: tb/tb_fft_r2_stage_sequencer.sv
// Bench for fft_r2_stage_sequencer at N_LOG2=3, RD_LAT=1, PIPE_LAT=2.
// Expected behaviour comes from a butterfly-list schedule model plus
// literal vector tables for the nominal frame.
module tb_fft_r2_stage_sequencer;

  localparam int L    = 3;
  localparam int NH   = 4;
  localparam int NQ   = 2;
  localparam int RDL  = 1;
  localparam int PL   = 2;
  localparam int MAXC = 160;

  logic       clk = 1'b0;
  logic       rst, start, cfg_modify, hold;
  logic       busy, done, rd_en, bf_en, bf_en_modify, wr_en;
  logic [1:0] stage;
  logic [2:0] rd_a, rd_b, wr_a, wr_b;
  logic [1:0] tw, tw2;

  always #5 clk = ~clk;

  fft_r2_stage_sequencer #(
    .N_LOG2   (3),
    .TW_W     (2),
    .RD_LAT   (1),
    .PIPE_LAT (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_cfg_modify   (cfg_modify),
    .i_hold         (hold),
    .o_busy         (busy),
    .o_done         (done),
    .o_stage        (stage),
    .o_rd_en        (rd_en),
    .o_rd_addr_a    (rd_a),
    .o_rd_addr_b    (rd_b),
    .o_tw_addr      (tw),
    .o_tw2_addr     (tw2),
    .o_bf_en        (bf_en),
    .o_bf_en_modify (bf_en_modify),
    .o_wr_en        (wr_en),
    .o_wr_addr_a    (wr_a),
    .o_wr_addr_b    (wr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit hold_pat [MAXC];
  int e_rd [MAXC], e_a [MAXC], e_b [MAXC], e_tw [MAXC], e_tw2 [MAXC];
  int e_bf [MAXC], e_bm [MAXC], e_wr [MAXC], e_wa [MAXC], e_wb [MAXC];
  int e_busy [MAXC], e_done [MAXC];
  int done_c;
  int c_rd [MAXC], c_a [MAXC], c_b [MAXC], c_tw [MAXC], c_tw2 [MAXC];
  int c_wr [MAXC], c_busy [MAXC], c_done [MAXC], c_bm [MAXC];

  typedef struct {
    int rel; int rd; int a; int b; int tw; int tw2;
  } rd_vec_t;
  typedef struct {
    int rel; int wr; int busy; int done; int bm_on;
  } tail_vec_t;

  rd_vec_t   rd_tab   [16];
  tail_vec_t tail_tab [8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int rev3(input int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  // Schedule model: list butterflies stage by stage in FFT loop order,
  // place reads on non-held cycles, writes PIPE_LAT later, next stage one
  // cycle after the previous stage's last write.
  task automatic build_model(input bit mod);
    int c, last, span, a, b, t;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0; e_tw2[i] = 0;
      e_bf[i] = 0; e_bm[i] = 0; e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
      e_busy[i] = 0; e_done[i] = 0;
    end
    c = 1;
    last = 0;
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      for (int g = 0; g < NH / span; g++) begin
        for (int j = 0; j < span; j++) begin
          while (hold_pat[c] && c < MAXC - 40) c++;
          a = g * 2 * span + j;
          b = a + span;
          t = j * (NH / span);
          e_rd[c] = 1; e_a[c] = a; e_b[c] = b;
`ifdef FFT_SEQ_BITREV_EN
          if (s == 0) begin e_a[c] = rev3(a); e_b[c] = rev3(b); end
`endif
          e_tw[c] = t; e_tw2[c] = (t + NQ) % NH;
          e_bf[c + RDL] = 1;
          e_bm[c + RDL] = (mod && s == L - 1) ? 1 : 0;
          e_wr[c + PL] = 1; e_wa[c + PL] = a; e_wb[c + PL] = b;
          last = c;
          c++;
        end
      end
      c = last + PL + 1;
    end
    done_c = last + PL + 1;
    e_done[done_c] = 1;
    for (int i = 1; i < done_c; i++) e_busy[i] = 1;
  endtask

  task automatic capture(input int r);
    c_rd[r] = int'(rd_en); c_a[r] = int'(rd_a); c_b[r] = int'(rd_b);
    c_tw[r] = int'(tw); c_tw2[r] = int'(tw2); c_wr[r] = int'(wr_en);
    c_busy[r] = int'(busy); c_done[r] = int'(done); c_bm[r] = int'(bf_en_modify);
  endtask

  task automatic cmp_cycle(input string tag, input int r);
    string p;
    p = $sformatf("%s@%0d", tag, r);
    check({p, " rd_en"}, 32'(rd_en), 32'(e_rd[r]));
    if (e_rd[r] != 0) begin
      check({p, " rd_a"}, 32'(rd_a), 32'(e_a[r]));
      check({p, " rd_b"}, 32'(rd_b), 32'(e_b[r]));
      check({p, " tw"},   32'(tw),   32'(e_tw[r]));
      check({p, " tw2"},  32'(tw2),  32'(e_tw2[r]));
    end
    check({p, " bf_en"},     32'(bf_en),        32'(e_bf[r]));
    check({p, " bf_modify"}, 32'(bf_en_modify), 32'(e_bm[r]));
    check({p, " wr_en"},     32'(wr_en),        32'(e_wr[r]));
    if (e_wr[r] != 0) begin
      check({p, " wr_a"}, 32'(wr_a), 32'(e_wa[r]));
      check({p, " wr_b"}, 32'(wr_b), 32'(e_wb[r]));
    end
    check({p, " busy"}, 32'(busy), 32'(e_busy[r]));
    check({p, " done"}, 32'(done), 32'(e_done[r]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},  32'(busy),  32'd0);
    check({tag, " done"},  32'(done),  32'd0);
    check({tag, " stage"}, 32'(stage), 32'd0);
    check({tag, " rd_en"}, 32'(rd_en), 32'd0);
    check({tag, " rd_a"},  32'(rd_a),  32'd0);
    check({tag, " rd_b"},  32'(rd_b),  32'd0);
    check({tag, " tw"},    32'(tw),    32'd0);
    check({tag, " tw2"},   32'(tw2),   32'd0);
    check({tag, " bf_en"}, 32'(bf_en), 32'd0);
    check({tag, " bf_mod"}, 32'(bf_en_modify), 32'd0);
    check({tag, " wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " wr_a"},  32'(wr_a),  32'd0);
    check({tag, " wr_b"},  32'(wr_b),  32'd0);
  endtask

  // Start a frame at the next edge, compare every cycle until a few idle
  // cycles past done; 'again' re-pulses start (to be ignored) in that cycle.
  task automatic run_frame(input bit mod, input int again, input string tag);
    build_model(mod);
    @(negedge clk);
    start = 1'b1;
    cfg_modify = mod;
    hold = hold_pat[0];
    for (int r = 0; r <= done_c + 3; r++) begin
      @(negedge clk);
      capture(r);
      cmp_cycle(tag, r);
      start = (r == again);
      cfg_modify = !mod;
      hold = hold_pat[r + 1];
    end
    start = 1'b0;
    hold = 1'b0;
  endtask

  task automatic check_tables(input bit mod, input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s tab rd_en@%0d", tag, rd_tab[i].rel), 32'(c_rd[rd_tab[i].rel]), 32'(rd_tab[i].rd));
      if (rd_tab[i].rd != 0) begin
        check($sformatf("%s tab rd_a@%0d", tag, rd_tab[i].rel), 32'(c_a[rd_tab[i].rel]), 32'(rd_tab[i].a));
        check($sformatf("%s tab rd_b@%0d", tag, rd_tab[i].rel), 32'(c_b[rd_tab[i].rel]), 32'(rd_tab[i].b));
        check($sformatf("%s tab tw@%0d", tag, rd_tab[i].rel), 32'(c_tw[rd_tab[i].rel]), 32'(rd_tab[i].tw));
        check($sformatf("%s tab tw2@%0d", tag, rd_tab[i].rel), 32'(c_tw2[rd_tab[i].rel]), 32'(rd_tab[i].tw2));
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s tail wr_en@%0d", tag, tail_tab[i].rel), 32'(c_wr[tail_tab[i].rel]), 32'(tail_tab[i].wr));
      check($sformatf("%s tail busy@%0d", tag, tail_tab[i].rel), 32'(c_busy[tail_tab[i].rel]), 32'(tail_tab[i].busy));
      check($sformatf("%s tail done@%0d", tag, tail_tab[i].rel), 32'(c_done[tail_tab[i].rel]), 32'(tail_tab[i].done));
      check($sformatf("%s tail bf_mod@%0d", tag, tail_tab[i].rel), 32'(c_bm[tail_tab[i].rel]),
            32'(mod ? tail_tab[i].bm_on : 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int ea4, eb4, ea5, eb5;

    // Nominal frame read schedule (hold low)
    rd_tab[0]  = '{1, 1, 0, 1, 0, 2};
    rd_tab[1]  = '{2, 1, 2, 3, 0, 2};
    rd_tab[2]  = '{3, 1, 4, 5, 0, 2};
    rd_tab[3]  = '{4, 1, 6, 7, 0, 2};
`ifdef FFT_SEQ_BITREV_EN
    rd_tab[0]  = '{1, 1, 0, 4, 0, 2};
    rd_tab[1]  = '{2, 1, 2, 6, 0, 2};
    rd_tab[2]  = '{3, 1, 1, 5, 0, 2};
    rd_tab[3]  = '{4, 1, 3, 7, 0, 2};
`endif
    rd_tab[4]  = '{5, 0, 0, 0, 0, 0};
    rd_tab[5]  = '{6, 0, 0, 0, 0, 0};
    rd_tab[6]  = '{7, 1, 0, 2, 0, 2};
    rd_tab[7]  = '{8, 1, 1, 3, 2, 0};
    rd_tab[8]  = '{9, 1, 4, 6, 0, 2};
    rd_tab[9]  = '{10, 1, 5, 7, 2, 0};
    rd_tab[10] = '{11, 0, 0, 0, 0, 0};
    rd_tab[11] = '{12, 0, 0, 0, 0, 0};
    rd_tab[12] = '{13, 1, 0, 4, 0, 2};
    rd_tab[13] = '{14, 1, 1, 5, 1, 3};
    rd_tab[14] = '{15, 1, 2, 6, 2, 0};
    rd_tab[15] = '{16, 1, 3, 7, 3, 1};
    // Final-stage tail: writes, busy, done, modify window
    tail_tab[0] = '{13, 0, 1, 0, 0};
    tail_tab[1] = '{14, 0, 1, 0, 1};
    tail_tab[2] = '{15, 1, 1, 0, 1};
    tail_tab[3] = '{16, 1, 1, 0, 1};
    tail_tab[4] = '{17, 1, 1, 0, 1};
    tail_tab[5] = '{18, 1, 1, 0, 0};
    tail_tab[6] = '{19, 0, 0, 1, 0};
    tail_tab[7] = '{20, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; cfg_modify = 1'b0; hold = 1'b0;
    for (int i = 0; i < MAXC; i++) hold_pat[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal frames, modify off then on
    run_frame(1'b0, -1, "nom0");
    check_tables(1'b0, "nom0");
    run_frame(1'b1, -1, "nom1");
    check_tables(1'b1, "nom1");

    // Hold over two issue cycles
    hold_pat[2] = 1'b1; hold_pat[3] = 1'b1;
    run_frame(1'b0, -1, "hold");
    ea4 = 2; eb4 = 3; ea5 = 4; eb5 = 5;
`ifdef FFT_SEQ_BITREV_EN
    ea4 = 2; eb4 = 6; ea5 = 1; eb5 = 5;
`endif
    check("hold rd_en@2", 32'(c_rd[2]), 32'd0);
    check("hold rd_en@3", 32'(c_rd[3]), 32'd0);
    check("hold rd_a@4", 32'(c_a[4]), 32'(ea4));
    check("hold rd_b@4", 32'(c_b[4]), 32'(eb4));
    check("hold rd_a@5", 32'(c_a[5]), 32'(ea5));
    check("hold rd_b@5", 32'(c_b[5]), 32'(eb5));
    check("hold done@21", 32'(c_done[21]), 32'd1);
    nw = 0;
    for (int i = 0; i < 25; i++) nw += c_wr[i];
    check("hold write count", 32'(nw), 32'd12);
    hold_pat[2] = 1'b0; hold_pat[3] = 1'b0;

    // Start pulses while busy and in the done cycle are ignored
    run_frame(1'b1, 5, "restart_busy");
    run_frame(1'b0, 18, "restart_done");

    // Mid-frame reset aborts cleanly, then a full frame runs
    build_model(1'b0);
    @(negedge clk);
    start = 1'b1; cfg_modify = 1'b0;
    for (int r = 0; r <= 8; r++) begin
      @(negedge clk);
      cmp_cycle("prerst", r);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst@9");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst@10");
    run_frame(1'b1, -1, "postrst");
    check_tables(1'b1, "postrst");

    // Random hold patterns and modify settings
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < MAXC; i++)
        hold_pat[i] = (i < 60) && ($urandom_range(0, 3) == 0);
      run_frame(1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_r2_stage_sequencer.md
Name: fft_r2_stage_sequencer

Overview:
- Control and address generator for an in-place, memory-based radix-2 DIT FFT.
- Drives one modified radix-2 butterfly datapath (two inputs, dual twiddle, en/en_modify controls), a dual-port sample RAM and a twiddle ROM.
- Steps through all stages and butterflies, aligns butterfly enables and write-back addresses with pipeline latency, and signals completion.
- Placement: between the frame-load logic and the butterfly/RAM datapath.

Parameters:
- N_LOG2, 4, log2 of FFT length N (N_LOG2 >= 2).
- TW_W, N_LOG2-1, twiddle ROM address width (N/2 entries).
- RD_LAT, 1, cycles from RAM/ROM address to data at butterfly inputs.
- PIPE_LAT, 3, cycles from read address to write-back of the same butterfly (PIPE_LAT >= RD_LAT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run one FFT frame.
- cfg_modify  in  1  latched at start; enables modified butterfly in the final stage.
- hold  in  1  stall request; freezes issue while high.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final write.
- stage  out  N_LOG2 bit count  current issuing stage.
- rd_en  out  1  RAM read strobe.
- rd_addr_a, rd_addr_b  out  N_LOG2  butterfly read addresses.
- tw_addr, tw2_addr  out  TW_W  twiddle ROM addresses, first and second multiplier.
- bf_en  out  1  butterfly enable, aligned with its input data.
- bf_en_modify  out  1  butterfly modify select, aligned with bf_en.
- wr_en  out  1  RAM write strobe.
- wr_addr_a, wr_addr_b  out  N_LOG2  write-back addresses.

Behaviour:
- Reset: state IDLE; all outputs 0; stage, counters and delay lines cleared.
- Reset mid-operation aborts the frame; wr_en is low in the cycle after reset.
- FSM states:
  - IDLE: start -> RUN, latch cfg_modify, k=0, s=0.
  - RUN: issue one butterfly per cycle unless hold. When k = N/2-1 issues: if s = N_LOG2-1 -> DRAIN_LAST, else -> DRAIN.
  - DRAIN: exactly PIPE_LAT cycles; hold ignored; then s++, k=0 -> RUN.
  - DRAIN_LAST: PIPE_LAT cycles -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- start is ignored outside IDLE.
- Timing: start sampled at edge T -> first rd_en in cycle T+1.
- busy is high in RUN, DRAIN and DRAIN_LAST, low in IDLE and DONE.
- Address generation (unsigned):
  - span = 1<<s
  - rd_addr_a = ((k>>s)<<(s+1)) | (k & (span-1))
  - rd_addr_b = rd_addr_a + span
  - tw_addr = (k & (span-1)) << (N_LOG2-1-s)
  - tw2_addr = tw_addr + N/4, modulo N/2
- All issue outputs are registered. rd_en, addresses and tw addresses change together.
- Alignment:
  - bf_en and bf_en_modify = rd_en and (cfg_modify && s==N_LOG2-1), delayed RD_LAT cycles.
  - wr_en, wr_addr_a, wr_addr_b = rd_en, rd_addr_a, rd_addr_b, delayed PIPE_LAT cycles.
- Hold:
  - During RUN, hold=1 forces rd_en=0 and freezes k and s.
  - The delay lines keep shifting, so in-flight butterflies complete.
- Hazard rule: the first read of stage s+1 occurs exactly one cycle after the last write of stage s.
- done asserts in the cycle after the final wr_en.

Optional Feature:
- Macro FFT_SEQ_BITREV_EN.
- Defined: stage-0 read addresses are bit-reversed over N_LOG2 bits. Input frames are stored in natural order; write addresses stay natural.
- Undefined: stage-0 read addresses use the plain formula; the loader must store input in bit-reversed order.

Decomposition:
- Shared fft_pkg holds:
  - FSM state encoding.
  - Bit-reverse function.
  - Constants N, N/2, N/4 derived from N_LOG2.
- Sub-module fft_seq_delay_line: parameterised depth/width shift register with synchronous clear. Instantiated twice, RD_LAT and PIPE_LAT.

Test Plan (N_LOG2=3, RD_LAT=1, PIPE_LAT=2, macro off, hold=0):
- start at T -> rd (a,b) cycles T+1..T+4: (0,1),(2,3),(4,5),(6,7); tw_addr 0 throughout; tw2_addr 2.
- Stage 1 -> rd_en low T+5..T+6. Reads T+7..T+10: (0,2) tw0, (1,3) tw2, (4,6) tw0, (5,7) tw2.
- Stage 2 -> reads T+13..T+16: (0,4) tw0, (1,5) tw1, (2,6) tw2, (3,7) tw3.
  - bf_en_modify=1 on T+14..T+17 only if cfg_modify=1.
  - Last wr_en at T+18, done at T+19, busy low at T+19.
- hold=1 during T+2..T+3 -> reads (2,3) and (4,5) move to T+4 and T+5; all later events shift +2; no write lost or duplicated.
- rst at T+8 -> all outputs 0 from T+9; new start runs a clean full sequence; start asserted while busy -> ignored.
- FFT_SEQ_BITREV_EN defined -> stage-0 reads (0,4),(2,6),(1,5),(3,7); writes (0,1),(2,3),(4,5),(6,7).
